// File: rtl/hw_accel_axim_pkg.sv
// Shared types and AXI encodings for the hw_accel AXI4 command master.
package hw_accel_axim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RESP
  } axim_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  // Packs to rsp_err = {timeout, resp_error}.
  typedef struct packed {
    logic timeout;
    logic resp_error;
  } axim_err_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/hw_accel_axi4_cmd_master.sv
// Single-outstanding AXI4 initiator turning cmd/rsp requests into single-beat register accesses.
// Optional bus-hang watchdog enabled by defining HW_ACCEL_AXIM_TIMEOUT_EN.
module hw_accel_axi4_cmd_master
  import hw_accel_axim_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter logic [7:0]  AXI_ID         = 8'h00,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_we,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                  rsp_err,
  output logic                        busy,
  output logic [7:0]                  axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [7:0]                  axi_awlen,
  output logic [2:0]                  axi_awsize,
  output logic [1:0]                  axi_awburst,
  output logic                        axi_awvalid,
  input  logic                        axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                        axi_wlast,
  output logic                        axi_wvalid,
  input  logic                        axi_wready,
  input  logic [7:0]                  axi_bid,
  input  logic [1:0]                  axi_bresp,
  input  logic                        axi_bvalid,
  output logic                        axi_bready,
  output logic [7:0]                  axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_araddr,
  output logic [7:0]                  axi_arlen,
  output logic [2:0]                  axi_arsize,
  output logic [1:0]                  axi_arburst,
  output logic                        axi_arvalid,
  input  logic                        axi_arready,
  input  logic [7:0]                  axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_rdata,
  input  logic [1:0]                  axi_rresp,
  input  logic                        axi_rlast,
  input  logic                        axi_rvalid,
  output logic                        axi_rready
);

  localparam int unsigned STRB_W   = AXI_DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam logic [2:0]  AXI_SIZE = 3'(ADDR_LSB);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  axim_state_e                 state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [AXI_DATA_WIDTH-1:0]   rdata_q;
  logic                        unaligned_q;
  logic                        aw_done_q;
  logic                        w_done_q;
  axim_err_t                   err_q;
  logic                        tmo_hit;
  logic                        tmo_fire;

  // Single-beat, full-width transfers only.
  assign axi_awid    = AXI_ID;
  assign axi_awaddr  = addr_q;
  assign axi_awlen   = 8'd0;
  assign axi_awsize  = AXI_SIZE;
  assign axi_awburst = AXI_BURST_INCR;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = '1;
  assign axi_wlast   = 1'b1;
  assign axi_arid    = AXI_ID;
  assign axi_araddr  = addr_q;
  assign axi_arlen   = 8'd0;
  assign axi_arsize  = AXI_SIZE;
  assign axi_arburst = AXI_BURST_INCR;

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != ST_IDLE);

`ifdef HW_ACCEL_AXIM_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             wait_st;

  assign wait_st = (state_q == ST_WR_ADDR_DATA) || (state_q == ST_WR_RESP) ||
                   (state_q == ST_RD_ADDR)      || (state_q == ST_RD_DATA);
  assign tmo_hit = wait_st && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)                              tmo_cnt_q <= '0;
    else if (!wait_st || state_d != state_q) tmo_cnt_q <= '0;
    else                                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // All AXI outputs decode from registered state only, so no input-to-output path.
  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    axi_arvalid = 1'b0;
    axi_bready  = 1'b0;
    axi_rready  = 1'b0;
    tmo_fire    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid) state_d = cmd_we ? ST_WR_ADDR_DATA : ST_RD_ADDR;
      end
      ST_WR_ADDR_DATA: begin
        axi_awvalid = !aw_done_q;
        axi_wvalid  = !w_done_q;
        if ((aw_done_q || axi_awready) && (w_done_q || axi_wready)) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        axi_bready = 1'b1;
        if (axi_bvalid) state_d = ST_RESP;
      end
      ST_RD_ADDR: begin
        axi_arvalid = 1'b1;
        if (axi_arready) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        axi_rready = 1'b1;
        if (axi_rvalid) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A real completion in the same cycle as the watchdog wins.
    if (tmo_hit && state_d == state_q) begin
      tmo_fire = 1'b1;
      state_d  = ST_RESP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      unaligned_q <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q      <= {cmd_addr[AXI_ADDR_WIDTH-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
            wdata_q     <= cmd_we ? cmd_wdata : '0;
            unaligned_q <= |cmd_addr[ADDR_LSB-1:0];
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
          end
        end
        ST_WR_ADDR_DATA: begin
          if (axi_awready) aw_done_q <= 1'b1;
          if (axi_wready)  w_done_q  <= 1'b1;
        end
        ST_WR_RESP: begin
          if (axi_bvalid) begin
            rdata_q <= '0;
            err_q   <= '{timeout: 1'b0,
                         resp_error: unaligned_q | resp_is_err(axi_bresp) | (axi_bid != AXI_ID)};
          end
        end
        ST_RD_DATA: begin
          if (axi_rvalid) begin
            rdata_q <= axi_rdata;
            err_q   <= '{timeout: 1'b0,
                         resp_error: unaligned_q | resp_is_err(axi_rresp) |
                                     (axi_rid != AXI_ID) | !axi_rlast};
          end
        end
        default: ;
      endcase
      if (tmo_fire) begin
        rdata_q <= '0;
        err_q   <= '{timeout: 1'b1, resp_error: unaligned_q};
      end
    end
  end

endmodule

// File: tb/tb_hw_accel_axi4_cmd_master.sv
// Directed + randomized bench for hw_accel_axi4_cmd_master with a cycle-stepped AXI slave and memory model.
module tb_hw_accel_axi4_cmd_master;
  import hw_accel_axim_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        busy;
  logic [7:0]  axi_awid, axi_awlen, axi_bid, axi_arid, axi_arlen, axi_rid;
  logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
  logic [2:0]  axi_awsize, axi_arsize;
  logic [1:0]  axi_awburst, axi_arburst, axi_bresp, axi_rresp;
  logic [3:0]  axi_wstrb;
  logic        axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
  logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready;
  logic        axi_rlast, axi_rvalid, axi_rready;

  int total = 0;
  int bad   = 0;
  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  hw_accel_axi4_cmd_master #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID(8'h00), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One command through a slave with given ready/response delays; expectations come
  // from the transaction rules, not from DUT state.
  task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                         input int a_d, input int w_d, input int r_d, input logic [1:0] resp,
                         input bit bad_id, input bit no_last, input int hold,
                         input logic [31:0] rd);
    logic [31:0] exp_addr, exp_rd;
    logic [1:0]  exp_err;
    int cyc, a_hi, w_hi, done_cyc;
    bit a_ok, w_ok, r_ok, rv, stable;
    exp_addr = {addr[31:2], 2'b00};
    exp_err  = {1'b0, (addr[1:0] != 2'b00) || (resp != AXI_RESP_OKAY) || bad_id || (!we && no_last)};
    exp_rd   = we ? 32'h0 : rd;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd; rsp_ready = 1'b0;
    chk("cmd_ready_idle", cmd_ready, 1);
    step();
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;
    cyc = 1; a_hi = 0; w_hi = 0; a_ok = 0; w_ok = !we; r_ok = 0; done_cyc = -1;
    while (!rsp_valid && cyc < 200) begin
      axi_awready = we && (cyc > a_d);
      axi_wready  = we && (cyc > w_d);
      axi_arready = !we && (cyc > a_d);
      rv = !r_ok && done_cyc >= 0 && cyc > done_cyc + r_d;
      axi_bvalid = we && rv;
      axi_rvalid = !we && rv;
      axi_bresp = resp; axi_rresp = resp;
      axi_bid = bad_id ? 8'h5A : 8'h00; axi_rid = axi_bid;
      axi_rlast = !no_last; axi_rdata = rd;
      if (we) begin
        if (axi_awvalid) a_hi++;
        if (axi_wvalid) w_hi++;
        if (axi_awvalid && axi_awready && !a_ok) begin
          a_ok = 1; chk("awaddr", axi_awaddr, exp_addr);
        end
        if (axi_wvalid && axi_wready && !w_ok) begin
          w_ok = 1; chk("wdata", axi_wdata, wd); chk("wstrb", axi_wstrb, 4'hF);
        end
        if (rv && axi_bready) r_ok = 1;
      end else begin
        if (axi_arvalid) a_hi++;
        if (axi_arvalid && axi_arready && !a_ok) begin
          a_ok = 1; chk("araddr", axi_araddr, exp_addr);
        end
        if (rv && axi_rready) r_ok = 1;
      end
      if (a_ok && w_ok && done_cyc < 0) done_cyc = cyc;
      step();
      cyc++;
    end
    axi_awready = 0; axi_wready = 0; axi_arready = 0; axi_bvalid = 0; axi_rvalid = 0;
    chk("rsp_within_bound", cyc < 200, 1);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err", rsp_err, exp_err);
    chk("addr_valid_cycles", a_hi, a_d + 1);
    if (we) chk("wvalid_cycles", w_hi, w_d + 1);
    chk("resp_beat_taken", r_ok, 1);
    if (a_d == 0 && w_d == 0 && r_d == 0) chk("latency", cyc, 3);
    stable = 1;
    for (int i = 0; i < hold; i++) begin
      if (!(rsp_valid === 1'b1 && rsp_rdata === exp_rd && rsp_err === exp_err &&
            cmd_ready === 1'b0 && busy === 1'b1 && axi_bready === 1'b0 && axi_rready === 1'b0))
        stable = 0;
      step();
    end
    if (hold > 0) chk("rsp_hold_stable", stable, 1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_cleared", rsp_valid, 0);
    chk("busy_cleared", busy, 0);
    chk("cmd_ready_back", cmd_ready, 1);
    if (we && exp_err == 2'b00) mem[exp_addr] = wd;
  endtask

  initial begin
    logic [31:0] a, d, rd;
    logic [1:0]  rs;
    int sel, cyc;
    bit we;
    rst = 1'b1; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
    axi_awready = 0; axi_wready = 0; axi_bid = 0; axi_bresp = 0; axi_bvalid = 0;
    axi_arready = 0; axi_rid = 0; axi_rdata = 0; axi_rresp = 0; axi_rlast = 0; axi_rvalid = 0;
    repeat (3) step();
    chk("rst_valids", {cmd_ready, rsp_valid, busy, axi_awvalid, axi_wvalid, axi_arvalid,
                       axi_bready, axi_rready}, 8'h00);
    chk("rst_data", {rsp_rdata, rsp_err, axi_awaddr[15:0]}, 50'h0);
    chk("rst_wdata", axi_wdata, 32'h0);
    rst = 1'b0;
    step();
    chk("consts", {axi_awid, axi_awlen, axi_awsize, axi_awburst, axi_wlast,
                   axi_arid, axi_arlen, axi_arsize, axi_arburst},
        {8'h00, 8'h00, 3'd2, AXI_BURST_INCR, 1'b1, 8'h00, 8'h00, 3'd2, AXI_BURST_INCR});

    run_txn(1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 0, AXI_RESP_OKAY, 0, 0, 0, 32'h0);
    run_txn(0, 32'h0000_0008, 32'h0, 0, 0, 0, AXI_RESP_OKAY, 0, 0, 0, 32'hCBCD_5678);
    run_txn(1, 32'h0000_0014, 32'h1234_5678, 5, 0, 0, AXI_RESP_OKAY, 0, 0, 0, 32'h0);
    run_txn(1, 32'h0000_0018, 32'h0BAD_F00D, 0, 0, 0, AXI_RESP_SLVERR, 0, 0, 4, 32'h0);
    run_txn(1, 32'h0000_001C, 32'hA5A5_5A5A, 0, 3, 2, AXI_RESP_OKAY, 0, 0, 0, 32'h0);
    run_txn(0, 32'h0000_0013, 32'h0, 1, 0, 1, AXI_RESP_OKAY, 0, 0, 1, 32'h7777_0001);
    run_txn(0, 32'h0000_0020, 32'h0, 0, 0, 0, AXI_RESP_OKAY, 1, 0, 0, 32'h1111_2222);
    run_txn(0, 32'h0000_0024, 32'h0, 0, 0, 0, AXI_RESP_OKAY, 0, 1, 0, 32'h3333_4444);

    // Reset while the write address phase is pending.
    cmd_valid = 1; cmd_we = 1; cmd_addr = 32'h40; cmd_wdata = 32'hFEED_0001;
    step();
    cmd_valid = 0;
    chk("awvalid_before_rst", axi_awvalid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_drop", {axi_awvalid, axi_wvalid, busy}, 3'b000);
    axi_bvalid = 1; axi_bresp = AXI_RESP_OKAY;
    chk("late_b_ignored", axi_bready, 0);
    step();
    axi_bvalid = 0;
    chk("idle_after_rst", cmd_ready, 1);
    run_txn(0, 32'h0000_0010, 32'h0, 0, 0, 0, AXI_RESP_OKAY, 0, 0, 0, mem[32'h10]);

`ifdef HW_ACCEL_AXIM_TIMEOUT_EN
    cmd_valid = 1; cmd_we = 0; cmd_addr = 32'h80;
    step();
    cmd_valid = 0;
    cyc = 1;
    while (!rsp_valid && cyc < 100) begin
      step();
      cyc++;
    end
    chk("tmo_latency", cyc, 17);
    chk("tmo_err", rsp_err, 2'b10);
    chk("tmo_rdata", rsp_rdata, 32'h0);
    chk("tmo_arvalid_dropped", axi_arvalid, 0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("tmo_back_idle", cmd_ready, 1);
`endif

    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1));
      a  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      d   = $urandom;
      sel = $urandom_range(0, 9);
      rs  = (sel == 0) ? AXI_RESP_SLVERR : (sel == 1) ? AXI_RESP_DECERR : AXI_RESP_OKAY;
      rd  = mem.exists({a[31:2], 2'b00}) ? mem[{a[31:2], 2'b00}] : $urandom;
      run_txn(we, a, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), rs,
              $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2), rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
